// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer driver slice.
//   - FSM state encoding used by timer_driver
//   - default values for PRESCALE / CLR_CYCLES / MAX_TICKS
//   - counter width and a saturating-increment helper
package timer_pkg;

    localparam int CNT_W = 16;

    localparam int              DEF_PRESCALE   = 5000;
    localparam int              DEF_CLR_CYCLES = 2;
    localparam logic [CNT_W-1:0] DEF_MAX_TICKS = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLEARING = 2'd1,
        ST_RUNNING  = 2'd2,
        ST_EXPIRED  = 2'd3
    } timer_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_driver_prescaler.sv
// tick_prescaler: free-running 0..PRESCALE-1 counter with a wrap strobe.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - synchronous clear to zero (wins over enable)
//   enable      - count while high, hold while low
//   wrap        - high in the cycle the count sits at PRESCALE-1 while enabled
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_r;

    assign wrap = enable && (count_r == LAST);

    // Prescale counter: clear, wrap back to zero, or advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (count_r == LAST) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + 16'd1;
            end
        end
    end

endmodule

// File: rtl/timer_driver.sv
// timer_driver: drives an external timeout counter with tick / clear pulses
// and watches its timer_reached level.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start, kick, stop    - one-cycle requests (stop > start > kick)
//   timer_reached        - level from the counter, possibly asynchronous
//   tick, timer_clear    - registered pulses to the counter
//   running              - high in RUNNING
//   expired, fault       - sticky results held while in EXPIRED
//   ticks_issued         - ticks since last clear, saturating
module timer_driver
    import timer_pkg::*;
#(
    parameter int               PRESCALE   = DEF_PRESCALE,
    parameter int               CLR_CYCLES = DEF_CLR_CYCLES,
    parameter logic [CNT_W-1:0] MAX_TICKS  = DEF_MAX_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kick,
    input  logic             stop,
    input  logic             timer_reached,
    output logic             tick,
    output logic             timer_clear,
    output logic             running,
    output logic             expired,
    output logic             fault,
    output logic [CNT_W-1:0] ticks_issued
);

    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    timer_state_t     state_r;
    logic [1:0]       sync_r;
    logic [3:0]       clr_cnt_r;
    logic [CNT_W-1:0] ticks_r;
    logic             tick_r;
    logic             timer_clear_r;
    logic             running_r;
    logic             expired_r;
    logic             fault_r;

    logic reached_s;
    logic in_run_s;
    logic fault_hit_s;
    logic go_clear_s;
    logic abort_s;
    logic presc_en_s;
    logic wrap_s;

    assign reached_s   = sync_r[1];
    assign in_run_s    = (state_r == ST_RUNNING);
    assign fault_hit_s = (ticks_r == MAX_TICKS);

    // start re-arms from any state except CLEARING; kick only restarts RUNNING.
    assign go_clear_s = (start && (state_r != ST_CLEARING)) || (kick && in_run_s);

    // Any higher-priority event in RUNNING swallows a coincident prescaler
    // wrap, so the prescaler is held cleared and never strobes that cycle.
    assign abort_s    = stop || start || kick || reached_s || fault_hit_s;
    assign presc_en_s = in_run_s && !abort_s;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (!presc_en_s),
        .enable (presc_en_s),
        .wrap   (wrap_s)
    );

    // Two-flop synchronizer for the asynchronous timer_reached level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], timer_reached};
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            clr_cnt_r     <= 4'd0;
            ticks_r       <= {CNT_W{1'b0}};
            tick_r        <= 1'b0;
            timer_clear_r <= 1'b0;
            running_r     <= 1'b0;
            expired_r     <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (stop) begin
                state_r       <= ST_IDLE;
                clr_cnt_r     <= 4'd0;
                ticks_r       <= {CNT_W{1'b0}};
                timer_clear_r <= 1'b0;
                running_r     <= 1'b0;
                expired_r     <= 1'b0;
                fault_r       <= 1'b0;
            end else if (go_clear_s) begin
                state_r       <= ST_CLEARING;
                clr_cnt_r     <= 4'd0;
                ticks_r       <= {CNT_W{1'b0}};
                timer_clear_r <= 1'b1;
                running_r     <= 1'b0;
                expired_r     <= 1'b0;
                fault_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        timer_clear_r <= 1'b0;
                    end
                    ST_CLEARING: begin
                        if (clr_cnt_r == CLR_LAST) begin
                            state_r       <= ST_RUNNING;
                            timer_clear_r <= 1'b0;
                            running_r     <= 1'b1;
                        end else begin
                            clr_cnt_r <= clr_cnt_r + 4'd1;
                        end
                    end
                    ST_RUNNING: begin
                        if (reached_s) begin
                            state_r   <= ST_EXPIRED;
                            running_r <= 1'b0;
                            expired_r <= 1'b1;
                        end else if (fault_hit_s) begin
                            state_r   <= ST_EXPIRED;
                            running_r <= 1'b0;
                            fault_r   <= 1'b1;
                        end else if (wrap_s) begin
                            tick_r  <= 1'b1;
                            ticks_r <= sat_inc(ticks_r);
                        end
                    end
                    ST_EXPIRED: begin
                        running_r <= 1'b0;
                    end
                    default: begin
                        state_r       <= ST_IDLE;
                        timer_clear_r <= 1'b0;
                        running_r     <= 1'b0;
                        expired_r     <= 1'b0;
                        fault_r       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tick         = tick_r;
    assign timer_clear  = timer_clear_r;
    assign running      = running_r;
    assign expired      = expired_r;
    assign fault        = fault_r;
    assign ticks_issued = ticks_r;

endmodule

// File: tb/tb_timer_driver.sv
// tb_timer_driver: scoreboard bench for timer_driver with PRESCALE=4,
// CLR_CYCLES=2, MAX_TICKS=12. Expected tick cycles/counts are queued when a
// start or kick is driven and popped by a monitor whenever tick is seen.
module tb_timer_driver;

    localparam int PRESC = 4;
    localparam int CLR   = 2;
    localparam int MAXT  = 12;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kick;
    logic        stop;
    logic        timer_reached;
    logic        tick;
    logic        timer_clear;
    logic        running;
    logic        expired;
    logic        fault;
    logic [15:0] ticks_issued;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc     = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    timer_driver #(
        .PRESCALE   (PRESC),
        .CLR_CYCLES (CLR),
        .MAX_TICKS  (16'd12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .kick          (kick),
        .stop          (stop),
        .timer_reached (timer_reached),
        .tick          (tick),
        .timer_clear   (timer_clear),
        .running       (running),
        .expired       (expired),
        .fault         (fault),
        .ticks_issued  (ticks_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Tick monitor: every observed tick must match the head of the queue.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_tick", 32'(tick), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("tick_cycle", cyc, mon_e.cyc);
                check_eq("tick_count", 32'(ticks_issued), mon_e.cnt);
                check_eq("tick_with_clear", 32'(timer_clear), 32'd0);
            end
        end
    end

    // Drive a one-cycle request just after a negedge; queue the ticks it should produce.
    task automatic pulse(input logic s, input logic k, input logic p, input int nticks);
        int   c0;
        exp_t e;
        c0 = cyc + 1;
        for (int i = 1; i <= nticks; i++) begin
            e.cyc = c0 + CLR + PRESC * i;
            e.cnt = i;
            exp_q.push_back(e);
        end
        start = s;
        kick  = k;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        kick  = 1'b0;
        stop  = 1'b0;
    endtask

    // Called in the first CLEARING cycle: two clear cycles then RUNNING.
    task automatic check_clear_seq();
        check_eq("clr1_timer_clear", 32'(timer_clear), 32'd1);
        check_eq("clr1_running", 32'(running), 32'd0);
        check_eq("clr1_ticks", 32'(ticks_issued), 32'd0);
        @(negedge clk);
        check_eq("clr2_timer_clear", 32'(timer_clear), 32'd1);
        @(negedge clk);
        check_eq("run_timer_clear", 32'(timer_clear), 32'd0);
        check_eq("run_running", 32'(running), 32'd1);
    endtask

    // Wait (bounded) for the tick that brings ticks_issued to n.
    task automatic wait_tick(input int n);
        int budget;
        budget = n * PRESC + 40;
        do begin
            @(negedge clk);
            budget--;
        end while (!(tick === 1'b1 && ticks_issued == 16'(n)) && budget > 0);
        if (!(tick === 1'b1 && ticks_issued == 16'(n))) begin
            check_eq("wait_tick", {15'd0, tick, ticks_issued}, {15'd0, 1'b1, 16'(n)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; kick = 1'b0; stop = 1'b0; timer_reached = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_timer_clear", 32'(timer_clear), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_expired", 32'(expired), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_ticks", 32'(ticks_issued), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_running", 32'(running), 32'd0);

        // kick in IDLE does nothing
        pulse(1'b0, 1'b1, 1'b0, 0);
        check_eq("idle_kick_clear", 32'(timer_clear), 32'd0);
        check_eq("idle_kick_running", 32'(running), 32'd0);

        // start, ten ticks, then timer_reached -> genuine expiry
        pulse(1'b1, 1'b0, 1'b0, 10);
        check_clear_seq();
        wait_tick(10);
        timer_reached = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("exp_expired", 32'(expired), 32'd1);
        check_eq("exp_fault", 32'(fault), 32'd0);
        check_eq("exp_running", 32'(running), 32'd0);
        check_eq("exp_ticks", 32'(ticks_issued), 32'd10);
        repeat (8) @(negedge clk);
        check_eq("exp_pending", exp_q.size(), 32'd0);
        pulse(1'b0, 1'b1, 1'b0, 0);
        check_eq("exp_kick_expired", 32'(expired), 32'd1);
        check_eq("exp_kick_clear", 32'(timer_clear), 32'd0);
        timer_reached = 1'b0;
        repeat (3) @(negedge clk);

        // start from EXPIRED, reached held low -> fault after MAXT ticks
        pulse(1'b1, 1'b0, 1'b0, MAXT);
        check_eq("restart_expired", 32'(expired), 32'd0);
        check_clear_seq();
        wait_tick(MAXT);
        @(negedge clk);
        check_eq("flt_fault", 32'(fault), 32'd1);
        check_eq("flt_expired", 32'(expired), 32'd0);
        check_eq("flt_running", 32'(running), 32'd0);
        repeat (8) @(negedge clk);
        check_eq("flt_ticks", 32'(ticks_issued), 32'd12);
        check_eq("flt_pending", exp_q.size(), 32'd0);

        // start clears the fault and re-arms
        pulse(1'b1, 1'b0, 1'b0, 3);
        check_eq("reclr_fault", 32'(fault), 32'd0);
        check_clear_seq();

        // kick on the wrap cycle preceding tick 3: that tick is suppressed
        wait_tick(2);
        repeat (3) @(negedge clk);
        void'(exp_q.pop_back());
        pulse(1'b0, 1'b1, 1'b0, 2);
        check_eq("kick_tick", 32'(tick), 32'd0);
        check_eq("kick_ticks", 32'(ticks_issued), 32'd0);
        check_clear_seq();
        wait_tick(2);

        // stop + start + kick together: stop wins
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b1, 1'b1, 0);
        check_eq("ssk_running", 32'(running), 32'd0);
        check_eq("ssk_clear", 32'(timer_clear), 32'd0);
        check_eq("ssk_expired", 32'(expired), 32'd0);
        check_eq("ssk_fault", 32'(fault), 32'd0);
        check_eq("ssk_tick", 32'(tick), 32'd0);
        check_eq("ssk_ticks", 32'(ticks_issued), 32'd0);
        repeat (10) @(negedge clk);
        check_eq("ssk_pending", exp_q.size(), 32'd0);

        // reset in the middle of CLEARING acts immediately
        pulse(1'b1, 1'b0, 1'b0, 0);
        check_eq("mid_clear_before", 32'(timer_clear), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_clear_async", 32'(timer_clear), 32'd0);
        check_eq("mid_clear_running", 32'(running), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("post_rst_running", 32'(running), 32'd0);
        check_eq("post_rst_clear", 32'(timer_clear), 32'd0);
        check_eq("post_rst_pending", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
